// File: rtl/reset_sequencer_if.sv
// Purpose : signal bundle between the reset sequencer and its environment.
// Signals : pll_locked   - PLL lock, asynchronous to the core clock
//           soft_rst_req - one-cycle request to re-run the delay/stage sequence
//           wdt_kick     - watchdog kick pulse (used only with RESET_SEQ_WDT_EN)
//           rst_out_n    - per-stage active-low resets
//           stable       - all stages released
//           lock_lost    - sticky lock-loss flag
// Modports: master drives the requests, slave is the sequencer itself.
interface reset_sequencer_if #(
    parameter int unsigned STAGES = 2
);
    logic              pll_locked;
    logic              soft_rst_req;
    logic              wdt_kick;
    logic [STAGES-1:0] rst_out_n;
    logic              stable;
    logic              lock_lost;

    modport master (
        output pll_locked, soft_rst_req, wdt_kick,
        input  rst_out_n, stable, lock_lost
    );

    modport slave (
        input  pll_locked, soft_rst_req, wdt_kick,
        output rst_out_n, stable, lock_lost
    );
endinterface

// File: rtl/reset_sequencer.sv
// Purpose : filters PLL lock, waits a release delay, then releases STAGES
//           active-low resets in order, STAGE_GAP cycles apart. Re-arms on
//           lock loss (back to lock filtering) or soft-reset request (back to
//           the release delay).
// Ports   : i_clk_core - core clock, all logic on posedge
//           i_resetn   - synchronous active-low master reset
//           bus        - reset_sequencer_if.slave (lock, requests, resets, status)
// Options : RESET_SEQ_WDT_EN enables a watchdog in RUN that re-arms the
//           sequence like a soft reset when not kicked within WDT_CYCLES.
module reset_sequencer #(
    parameter int unsigned LOCK_FILTER   = 4,
    parameter int unsigned RELEASE_DELAY = 128,
    parameter int unsigned STAGES        = 2,
    parameter int unsigned STAGE_GAP     = 16,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned WDT_CYCLES    = 4096
) (
    input  logic               i_clk_core,
    input  logic               i_resetn,
    reset_sequencer_if.slave   bus
);

    localparam int unsigned K_W   = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int unsigned CNT_LIM = 1 << CNT_W;

    // Parameter sanity: the counter must hold every terminal value.
    if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
        $error("reset_sequencer: CNT_W out of range");
    end
    if (LOCK_FILTER < 1 || LOCK_FILTER >= CNT_LIM) begin : g_bad_filter
        $error("reset_sequencer: LOCK_FILTER out of range for CNT_W");
    end
    if (RELEASE_DELAY < 1 || RELEASE_DELAY >= CNT_LIM) begin : g_bad_delay
        $error("reset_sequencer: RELEASE_DELAY out of range for CNT_W");
    end
    if (STAGE_GAP < 1 || STAGE_GAP >= CNT_LIM) begin : g_bad_gap
        $error("reset_sequencer: STAGE_GAP out of range for CNT_W");
    end
    if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
        $error("reset_sequencer: STAGES must be 1..8");
    end
    if (WDT_CYCLES < 1) begin : g_bad_wdt
        $error("reset_sequencer: WDT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        S_FILTER = 2'd0,
        S_DELAY  = 2'd1,
        S_STAGE  = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_sync1;
    logic              r_lock_s;
    logic [CNT_W-1:0]  r_cnt;
    logic [K_W-1:0]    r_k;
    logic [STAGES-1:0] r_rst_out_n;
    logic              r_stable;
    logic              r_lock_lost;

    logic              w_tmo;
    logic              w_rearm;

`ifdef RESET_SEQ_WDT_EN
    localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);

    logic [WDT_W-1:0] r_wdt;

    // Timeout fires on the edge the count would reach WDT_CYCLES; a kick in
    // that same cycle wins.
    assign w_tmo = (r_state == S_RUN) && !bus.wdt_kick &&
                   (r_wdt == WDT_W'(WDT_CYCLES - 1));

    // Watchdog only runs in RUN, so it is already zero on RUN entry.
    always_ff @(posedge i_clk_core) begin
        if (!i_resetn) begin
            r_wdt <= '0;
        end else if (r_state != S_RUN || bus.wdt_kick || w_tmo) begin
            r_wdt <= '0;
        end else begin
            r_wdt <= r_wdt + WDT_W'(1);
        end
    end
`else
    logic w_unused_wdt_kick;
    assign w_unused_wdt_kick = bus.wdt_kick;
    assign w_tmo             = 1'b0;
`endif

    assign w_rearm = w_tmo || bus.soft_rst_req;

    // Sequencer FSM, synchroniser and registered outputs.
    always_ff @(posedge i_clk_core) begin
        if (!i_resetn) begin
            r_state     <= S_FILTER;
            r_sync1     <= 1'b0;
            r_lock_s    <= 1'b0;
            r_cnt       <= '0;
            r_k         <= '0;
            r_rst_out_n <= '0;
            r_stable    <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_sync1  <= bus.pll_locked;
            r_lock_s <= r_sync1;

            if (r_state == S_FILTER) begin
                if (!r_lock_s) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_W'(LOCK_FILTER)) begin
                    r_state <= S_DELAY;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (!r_lock_s) begin
                // Lock loss beats any re-arm request and restarts filtering.
                r_state     <= S_FILTER;
                r_cnt       <= '0;
                r_rst_out_n <= '0;
                r_stable    <= 1'b0;
                r_lock_lost <= 1'b1;
            end else if (w_rearm) begin
                r_state     <= S_DELAY;
                r_cnt       <= '0;
                r_rst_out_n <= '0;
                r_stable    <= 1'b0;
            end else begin
                case (r_state)
                    S_DELAY: begin
                        if (r_cnt == CNT_W'(RELEASE_DELAY - 1)) begin
                            r_rst_out_n <= STAGES'(1);
                            r_cnt       <= '0;
                            r_k         <= K_W'(1);
                            if (STAGES == 1) begin
                                r_state  <= S_RUN;
                                r_stable <= 1'b1;
                            end else begin
                                r_state <= S_STAGE;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_STAGE: begin
                        if (r_cnt == CNT_W'(STAGE_GAP - 1)) begin
                            // OR-in keeps releases monotonic.
                            r_rst_out_n <= r_rst_out_n | (STAGES'(1) << r_k);
                            r_cnt       <= '0;
                            if (r_k == K_W'(STAGES - 1)) begin
                                r_state  <= S_RUN;
                                r_stable <= 1'b1;
                            end else begin
                                r_k <= r_k + K_W'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.rst_out_n = r_rst_out_n;
    assign bus.stable    = r_stable;
    assign bus.lock_lost = r_lock_lost;

endmodule
